// File: rtl/timing_decode_unit.sv
// Sequence counter, instruction register and opcode/timing decoder for the
// basic computer control unit; the run flip-flop gates every timing strobe.
module timing_decode_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hlt,
  input  logic        sc_clr,
  input  logic [15:0] bus,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic        I,
  output logic [15:0] B,
  output logic [15:0] ir,
  output logic        running
);

  logic [2:0]  sc_reg;
  logic [2:0]  sc_next;
  logic [15:0] ir_reg;
  logic [15:0] ir_next;
  logic        i_reg;
  logic        i_next;
  logic        s_reg;
  logic        s_next;

  logic        t1_end;
  logic        t2_end;

  // Fetch captures only complete while running; a halt in the same cycle wins.
  assign t1_end = s_reg && (sc_reg == 3'd1) && !hlt;
  assign t2_end = s_reg && (sc_reg == 3'd2) && !hlt;

  always_comb begin
    s_next  = s_reg;
    sc_next = sc_reg;
    ir_next = ir_reg;
    i_next  = i_reg;

    if (hlt) begin
      s_next = 1'b0;
    end else if (start) begin
      s_next = 1'b1;
    end

    // SC is already zero whenever S=0, so clearing it on hlt keeps the
    // restart-at-T0 guarantee without a separate idle case.
    if (hlt) begin
      sc_next = 3'd0;
    end else if (s_reg) begin
      if (sc_clr) begin
        sc_next = 3'd0;
      end else begin
        sc_next = sc_reg + 3'd1;
      end
    end

    if (t1_end) begin
      ir_next = bus;
    end

    if (t2_end) begin
      i_next = ir_reg[15];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg  <= 1'b0;
      sc_reg <= 3'd0;
      ir_reg <= 16'h0000;
      i_reg  <= 1'b0;
    end else begin
      s_reg  <= s_next;
      sc_reg <= sc_next;
      ir_reg <= ir_next;
      i_reg  <= i_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_decode
      assign T[gi] = s_reg && (sc_reg == gi[2:0]);
      assign D[gi] = (ir_reg[14:12] == gi[2:0]);
    end
  endgenerate

  assign I       = i_reg;
  assign B       = {4'b0000, ir_reg[11:0]};
  assign ir      = ir_reg;
  assign running = s_reg;

endmodule

// File: tb/tb_timing_decode_unit.sv
// Directed bench for timing_decode_unit: inputs are driven and outputs are
// sampled on the falling edge, so each step lands in the next cycle.
module tb_timing_decode_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hlt;
  logic        sc_clr;
  logic [15:0] bus;
  logic [7:0]  T;
  logic [7:0]  D;
  logic        I;
  logic [15:0] B;
  logic [15:0] ir;
  logic        running;

  int checks;
  int errors;

  timing_decode_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hlt     (hlt),
    .sc_clr  (sc_clr),
    .bus     (bus),
    .T       (T),
    .D       (D),
    .I       (I),
    .B       (B),
    .ir      (ir),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    $display("cycle rst=%0b start=%0b hlt=%0b sc_clr=%0b -> T=%02h D=%02h I=%0b ir=%04h running=%0b",
             rst, start, hlt, sc_clr, T, D, I, ir, running);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (T !== 8'h00) begin errors++; $display("FAIL reset_T got %02h want 00", T); end
    checks++; if (D !== 8'h01) begin errors++; $display("FAIL reset_D got %02h want 01", D); end
    checks++; if (I !== 1'b0) begin errors++; $display("FAIL reset_I got %0b want 0", I); end
    checks++; if (B !== 16'h0000) begin errors++; $display("FAIL reset_B got %04h want 0000", B); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %04h want 0000", ir); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %0b want 0", running); end
    // idle machine stays idle
    step();
    checks++; if (T !== 8'h00) begin errors++; $display("FAIL idle_T got %02h want 00", T); end
  endtask

  task automatic test_free_run();
    logic [7:0] seq [0:8];
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %0b want 1", running); end
    for (int k = 0; k < 9; k++) begin
      if (k != 0) step();
      checks++;
      if (T !== seq[k]) begin
        errors++; $display("FAIL run_T[%0d] got %02h want %02h", k, T, seq[k]);
      end
    end
    hlt = 1'b1;
    step();
    hlt = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_halt_running got %0b want 0", running); end
    checks++; if (T !== 8'h00) begin errors++; $display("FAIL run_halt_T got %02h want 00", T); end
  endtask

  task automatic test_fetch();
    start = 1'b1;
    step();                       // T0
    start = 1'b0;
    step();                       // T1
    checks++; if (T !== 8'h02) begin errors++; $display("FAIL fetch_T1 got %02h want 02", T); end
    bus = 16'h7800;
    step();                       // T2
    bus = 16'h0000;
    checks++; if (ir !== 16'h7800) begin errors++; $display("FAIL fetch_ir got %04h want 7800", ir); end
    checks++; if (D !== 8'h80) begin errors++; $display("FAIL fetch_D got %02h want 80", D); end
    step();                       // T3
    checks++; if (I !== 1'b0) begin errors++; $display("FAIL fetch_I got %0b want 0", I); end
    checks++; if (B !== 16'h0800) begin errors++; $display("FAIL fetch_B got %04h want 0800", B); end
    checks++; if ((T[3] & D[7] & ~I & B[11]) !== 1'b1) begin
      errors++; $display("FAIL fetch_clr_term got %0b want 1", T[3] & D[7] & ~I & B[11]);
    end
  endtask

  task automatic test_sc_clr();
    step();                       // T4
    step();                       // T5
    checks++; if (T !== 8'h20) begin errors++; $display("FAIL clr_T5 got %02h want 20", T); end
    sc_clr = 1'b1;
    step();                       // T0
    sc_clr = 1'b0;
    checks++; if (T !== 8'h01) begin errors++; $display("FAIL clr_T0 got %02h want 01", T); end
    checks++; if (ir !== 16'h7800) begin errors++; $display("FAIL clr_ir_T0 got %04h want 7800", ir); end
    step();                       // T1
    checks++; if (ir !== 16'h7800) begin errors++; $display("FAIL clr_ir_T1 got %04h want 7800", ir); end
  endtask

  task automatic test_indirect();
    bus = 16'hF400;               // driven during T1
    step();                       // T2
    bus = 16'h0000;
    checks++; if (ir !== 16'hF400) begin errors++; $display("FAIL ind_ir got %04h want F400", ir); end
    step();                       // T3
    checks++; if (I !== 1'b1) begin errors++; $display("FAIL ind_I got %0b want 1", I); end
    checks++; if (D !== 8'h80) begin errors++; $display("FAIL ind_D got %02h want 80", D); end
    checks++; if (B !== 16'h0400) begin errors++; $display("FAIL ind_B got %04h want 0400", B); end
  endtask

  task automatic test_halt();
    hlt   = 1'b1;                 // during T3, together with start
    start = 1'b1;
    step();
    hlt   = 1'b0;
    start = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL hlt_running got %0b want 0", running); end
    checks++; if (T !== 8'h00) begin errors++; $display("FAIL hlt_T got %02h want 00", T); end
    checks++; if (ir !== 16'hF400) begin errors++; $display("FAIL hlt_ir got %04h want F400", ir); end
    checks++; if (I !== 1'b1) begin errors++; $display("FAIL hlt_I got %0b want 1", I); end
    step();
    checks++; if (T !== 8'h00) begin errors++; $display("FAIL hlt_idle_T got %02h want 00", T); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (T !== 8'h01) begin errors++; $display("FAIL restart_T got %02h want 01", T); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart_running got %0b want 1", running); end
  endtask

  task automatic test_reset_mid();
    step();                       // T1
    bus = 16'h1234;
    step();                       // T2
    bus = 16'h0000;
    checks++; if (ir !== 16'h1234) begin errors++; $display("FAIL mid_ir got %04h want 1234", ir); end
    checks++; if (D !== 8'h02) begin errors++; $display("FAIL mid_D got %02h want 02", D); end
    step();                       // T3
    checks++; if (I !== 1'b0) begin errors++; $display("FAIL mid_I got %0b want 0", I); end
    step();                       // T4
    checks++; if (T !== 8'h10) begin errors++; $display("FAIL mid_T4 got %02h want 10", T); end
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    checks++; if (T !== 8'h00) begin errors++; $display("FAIL mid_rst_T got %02h want 00", T); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL mid_rst_ir got %04h want 0000", ir); end
    checks++; if (D !== 8'h01) begin errors++; $display("FAIL mid_rst_D got %02h want 01", D); end
    checks++; if (I !== 1'b0) begin errors++; $display("FAIL mid_rst_I got %0b want 0", I); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_rst_running got %0b want 0", running); end
    step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got %0b want 0", running); end
  endtask

  task automatic test_back_to_back();
    // short instructions: sc_clr at T2 three times in a row
    start = 1'b1;
    step();                       // T0
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();                     // T1
      bus = 16'h2005 + 16'(n);
      step();                     // T2
      bus = 16'h0000;
      checks++;
      if (ir !== (16'h2005 + 16'(n))) begin
        errors++; $display("FAIL b2b_ir[%0d] got %04h want %04h", n, ir, 16'h2005 + 16'(n));
      end
      checks++; if (D !== 8'h04) begin errors++; $display("FAIL b2b_D[%0d] got %02h want 04", n, D); end
      sc_clr = 1'b1;
      step();                     // T0
      sc_clr = 1'b0;
      checks++; if (T !== 8'h01) begin errors++; $display("FAIL b2b_T0[%0d] got %02h want 01", n, T); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    hlt    = 1'b0;
    sc_clr = 1'b0;
    bus    = 16'h0000;
    test_reset();
    test_free_run();
    test_fetch();
    test_sc_clr();
    test_indirect();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
